// File: rtl/shim_sts_pkg.sv
// Shared definitions for the SPI status event scheduler: group codes,
// scheduler state encoding, event word layout and small helpers.
package shim_sts_pkg;

    localparam int NUM_GROUPS = 13;
    localparam int CH_PER_GRP = 8;
    localparam int GRP_BITS   = 4;
    localparam int CH_BITS    = 3;
    localparam int EVT_WIDTH  = 16;
    localparam int STS_WIDTH  = NUM_GROUPS * CH_PER_GRP;

    // Group codes; the group index in sts_in is the code reported in the event word.
    localparam logic [GRP_BITS-1:0] GRP_SPI_OFF          = 4'd0;
    localparam logic [GRP_BITS-1:0] GRP_OVER_THRESH      = 4'd1;
    localparam logic [GRP_BITS-1:0] GRP_THRESH_UFL       = 4'd2;
    localparam logic [GRP_BITS-1:0] GRP_THRESH_OFL       = 4'd3;
    localparam logic [GRP_BITS-1:0] GRP_BAD_DAC_CMD      = 4'd4;
    localparam logic [GRP_BITS-1:0] GRP_DAC_CAL_OOB      = 4'd5;
    localparam logic [GRP_BITS-1:0] GRP_DAC_VAL_OOB      = 4'd6;
    localparam logic [GRP_BITS-1:0] GRP_DAC_BUF_UFL      = 4'd7;
    localparam logic [GRP_BITS-1:0] GRP_UNEXP_DAC_TRIG   = 4'd8;
    localparam logic [GRP_BITS-1:0] GRP_BAD_ADC_CMD      = 4'd9;
    localparam logic [GRP_BITS-1:0] GRP_ADC_CMD_BUF_UFL  = 4'd10;
    localparam logic [GRP_BITS-1:0] GRP_ADC_DATA_BUF_OFL = 4'd11;
    localparam logic [GRP_BITS-1:0] GRP_UNEXP_ADC_TRIG   = 4'd12;

    // Event word field positions.
    localparam int EVT_GRP_LSB = 12;
    localparam int EVT_CH_LSB  = 9;
    localparam int EVT_OVR_BIT = 8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SELECT  = 2'd1,
        ST_PRESENT = 2'd2
    } sched_state_e;

    // Index of the lowest set bit of a group's pending vector (0 if none).
    function automatic logic [CH_BITS-1:0] lowest_ch(input logic [CH_PER_GRP-1:0] v);
        lowest_ch = {CH_BITS{1'b0}};
        for (int i = CH_PER_GRP - 1; i >= 0; i--) begin
            lowest_ch = v[i] ? CH_BITS'(i) : lowest_ch;
        end
    endfunction

    // Assemble an event word; low byte is reserved and always zero.
    function automatic logic [EVT_WIDTH-1:0] pack_evt(input logic [GRP_BITS-1:0] grp,
                                                      input logic [CH_BITS-1:0]  ch,
                                                      input logic                ovr);
        pack_evt = {EVT_WIDTH{1'b0}};
        pack_evt[EVT_GRP_LSB +: GRP_BITS] = grp;
        pack_evt[EVT_CH_LSB +: CH_BITS]   = ch;
        pack_evt[EVT_OVR_BIT]             = ovr;
    endfunction

endpackage

// File: rtl/shim_sts_rr_arb.sv
// Combinational N-way round-robin arbiter: grants the first requester found
// scanning upward from ptr_i with wrap-around.
module shim_sts_rr_arb #(
    parameter int N = 13,
    parameter int W = 4
) (
    input  logic [N-1:0] req_i,
    input  logic [W-1:0] ptr_i,
    output logic [W-1:0] gnt_idx_o,
    output logic         gnt_vld_o
);

    // Scan candidates ptr, ptr+1, ... modulo N and keep the first one requesting.
    always_comb begin
        int   base;
        int   cand;
        logic hit;
        gnt_idx_o = {W{1'b0}};
        gnt_vld_o = 1'b0;
        for (int i = 0; i < N; i++) begin
            base      = int'(ptr_i) + i;
            cand      = (base >= N) ? (base - N) : base;
            hit       = !gnt_vld_o && req_i[cand];
            gnt_idx_o = hit ? W'(cand) : gnt_idx_o;
            gnt_vld_o = gnt_vld_o | hit;
        end
    end

endmodule

// File: rtl/shim_spi_sts_event_sched.sv
// SPI status event scheduler: captures rising edges of the synchronized
// status vectors as pending events, arbitrates round-robin across groups and
// serializes one encoded event word at a time on a valid/ready port.
module shim_spi_sts_event_sched
    import shim_sts_pkg::*;
(
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic [STS_WIDTH-1:0]  sts_in,
    input  logic [NUM_GROUPS-1:0] grp_en,
    input  logic                  clr_all,
    input  logic                  irq_en,
    output logic [EVT_WIDTH-1:0]  evt_data,
    output logic                  evt_valid,
    input  logic                  evt_ready,
    output logic                  irq,
    output logic                  pend_any
);

    logic [STS_WIDTH-1:0]  prev_q;
    logic [STS_WIDTH-1:0]  pend_q, pend_d;
    logic [STS_WIDTH-1:0]  en_mask_s;
    logic [STS_WIDTH-1:0]  rise_s;
    logic [STS_WIDTH-1:0]  pres_mask_s;
    logic [STS_WIDTH-1:0]  pend_keep_s;
    logic [NUM_GROUPS-1:0] ovr_q, ovr_d;
    logic [NUM_GROUPS-1:0] ovr_keep_s;
    logic [NUM_GROUPS-1:0] grp_req_s;
    logic [NUM_GROUPS-1:0] win_grp_oh_s;
    logic [GRP_BITS-1:0]   rr_ptr_q, rr_ptr_d;
    logic [GRP_BITS-1:0]   win_grp_q, win_grp_d;
    logic [GRP_BITS-1:0]   arb_grp_s;
    logic [CH_BITS-1:0]    win_ch_q, win_ch_d;
    logic [CH_BITS-1:0]    arb_ch_s;
    logic [CH_PER_GRP-1:0] arb_vec_s;
    logic                  arb_ovr_s;
    logic                  arb_vld_s;
    logic                  handshake_s;
    sched_state_e          state_q, state_d;
    logic [EVT_WIDTH-1:0]  evt_data_q, evt_data_d;
    logic                  evt_valid_q, evt_valid_d;
    logic                  irq_q;
    logic                  pend_any_q;

    // Per-bit enable mask: group enables widened, spi_off only has channel 0.
    always_comb begin
        en_mask_s = {STS_WIDTH{1'b0}};
        for (int g = 0; g < NUM_GROUPS; g++) begin
            en_mask_s[g*CH_PER_GRP +: CH_PER_GRP] = {CH_PER_GRP{grp_en[g]}};
        end
        en_mask_s[CH_PER_GRP-1:1] = {(CH_PER_GRP-1){1'b0}};
    end

    assign rise_s      = sts_in & ~prev_q & en_mask_s;
    assign handshake_s = (state_q == ST_PRESENT) && evt_valid_q && evt_ready;

    // Group request vector, winner one-hot, and the arbitrated group's pend/ovr.
    always_comb begin
        grp_req_s    = {NUM_GROUPS{1'b0}};
        win_grp_oh_s = {NUM_GROUPS{1'b0}};
        arb_vec_s    = {CH_PER_GRP{1'b0}};
        arb_ovr_s    = 1'b0;
        for (int g = 0; g < NUM_GROUPS; g++) begin
            grp_req_s[g]    = |pend_q[g*CH_PER_GRP +: CH_PER_GRP];
            win_grp_oh_s[g] = (win_grp_q == GRP_BITS'(g));
            arb_vec_s       = arb_vec_s | ((arb_grp_s == GRP_BITS'(g)) ?
                              pend_q[g*CH_PER_GRP +: CH_PER_GRP] : {CH_PER_GRP{1'b0}});
            arb_ovr_s       = arb_ovr_s | ((arb_grp_s == GRP_BITS'(g)) && ovr_q[g]);
        end
    end

    assign arb_ch_s = lowest_ch(arb_vec_s);

    // One-hot of the pend bit belonging to the word currently on the port.
    always_comb begin
        pres_mask_s = {STS_WIDTH{1'b0}};
        for (int g = 0; g < NUM_GROUPS; g++) begin
            for (int c = 0; c < CH_PER_GRP; c++) begin
                pres_mask_s[g*CH_PER_GRP + c] = (state_q == ST_PRESENT) && win_grp_oh_s[g] &&
                                                (win_ch_q == CH_BITS'(c));
            end
        end
    end

    shim_sts_rr_arb #(
        .N (NUM_GROUPS),
        .W (GRP_BITS)
    ) u_rr_arb (
        .req_i     (grp_req_s),
        .ptr_i     (rr_ptr_q),
        .gnt_idx_o (arb_grp_s),
        .gnt_vld_o (arb_vld_s)
    );

    // Pending/overrun next state: clears first (clr_all, acceptance), then new
    // rises, so a rise coinciding with its own clear leaves pend set and no overrun.
    always_comb begin
        if (clr_all) begin
            pend_keep_s = pend_q & pres_mask_s;
            ovr_keep_s  = {NUM_GROUPS{1'b0}};
        end else begin
            pend_keep_s = pend_q;
            ovr_keep_s  = ovr_q;
        end
        if (handshake_s) begin
            pend_keep_s = pend_keep_s & ~pres_mask_s;
            ovr_keep_s  = ovr_keep_s & ~win_grp_oh_s;
        end else begin
            pend_keep_s = pend_keep_s;
            ovr_keep_s  = ovr_keep_s;
        end
        ovr_d = ovr_keep_s;
        for (int g = 0; g < NUM_GROUPS; g++) begin
            ovr_d[g] = ovr_keep_s[g] |
                       (|(rise_s[g*CH_PER_GRP +: CH_PER_GRP] & pend_keep_s[g*CH_PER_GRP +: CH_PER_GRP]));
        end
        pend_d = pend_keep_s | rise_s;
    end

    // Scheduler FSM: pick a winner in SELECT, hold it in PRESENT until accepted.
    always_comb begin
        state_d     = state_q;
        evt_data_d  = evt_data_q;
        evt_valid_d = evt_valid_q;
        win_grp_d   = win_grp_q;
        win_ch_d    = win_ch_q;
        rr_ptr_d    = rr_ptr_q;
        case (state_q)
            ST_IDLE: begin
                evt_valid_d = 1'b0;
                if (pend_any_q) begin
                    state_d = ST_SELECT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SELECT: begin
                // A clear in this cycle removes the candidate before it is shown.
                if (clr_all || !arb_vld_s) begin
                    state_d     = ST_IDLE;
                    evt_valid_d = 1'b0;
                end else begin
                    win_grp_d   = arb_grp_s;
                    win_ch_d    = arb_ch_s;
                    evt_data_d  = pack_evt(arb_grp_s, arb_ch_s, arb_ovr_s);
                    evt_valid_d = 1'b1;
                    state_d     = ST_PRESENT;
                end
            end
            ST_PRESENT: begin
                if (handshake_s) begin
                    evt_valid_d = 1'b0;
                    rr_ptr_d    = (win_grp_q == GRP_BITS'(NUM_GROUPS - 1)) ?
                                  {GRP_BITS{1'b0}} : (win_grp_q + 4'd1);
                    if (|pend_d) begin
                        state_d = ST_SELECT;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    state_d     = ST_PRESENT;
                    evt_valid_d = evt_valid_q;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                evt_valid_d = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            prev_q      <= {STS_WIDTH{1'b0}};
            pend_q      <= {STS_WIDTH{1'b0}};
            ovr_q       <= {NUM_GROUPS{1'b0}};
            rr_ptr_q    <= {GRP_BITS{1'b0}};
            win_grp_q   <= {GRP_BITS{1'b0}};
            win_ch_q    <= {CH_BITS{1'b0}};
            state_q     <= ST_IDLE;
            evt_data_q  <= {EVT_WIDTH{1'b0}};
            evt_valid_q <= 1'b0;
            irq_q       <= 1'b0;
            pend_any_q  <= 1'b0;
        end else begin
            prev_q      <= sts_in;
            pend_q      <= pend_d;
            ovr_q       <= ovr_d;
            rr_ptr_q    <= rr_ptr_d;
            win_grp_q   <= win_grp_d;
            win_ch_q    <= win_ch_d;
            state_q     <= state_d;
            evt_data_q  <= evt_data_d;
            evt_valid_q <= evt_valid_d;
            irq_q       <= irq_en & (|pend_d);
            pend_any_q  <= |pend_d;
        end
    end

    assign evt_data  = evt_data_q;
    assign evt_valid = evt_valid_q;
    assign irq       = irq_q;
    assign pend_any  = pend_any_q;

endmodule

// File: tb/tb_shim_spi_sts_event_sched.sv
// Self-checking bench for shim_spi_sts_event_sched: directed scenarios plus a
// randomized run, all checked each cycle against a behavioural model.
module tb_shim_spi_sts_event_sched;

    localparam int NG = 13;
    localparam int NC = 8;
    localparam int SW = NG * NC;

    logic          aclk = 1'b0;
    logic          aresetn;
    logic [SW-1:0] sts_in;
    logic [NG-1:0] grp_en;
    logic          clr_all;
    logic          irq_en;
    logic [15:0]   evt_data;
    logic          evt_valid;
    logic          evt_ready;
    logic          irq;
    logic          pend_any;

    always #5 aclk = ~aclk;

    shim_spi_sts_event_sched dut (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .sts_in    (sts_in),
        .grp_en    (grp_en),
        .clr_all   (clr_all),
        .irq_en    (irq_en),
        .evt_data  (evt_data),
        .evt_valid (evt_valid),
        .evt_ready (evt_ready),
        .irq       (irq),
        .pend_any  (pend_any)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Behavioural model state.
    bit          m_prev [SW];
    bit          m_pend [NG][NC];
    bit          m_ovr  [NG];
    int          m_rr;
    int          m_phase;   // 0 waiting, 1 choosing, 2 showing a word
    int          m_wg;
    int          m_wc;
    logic [15:0] m_data;
    bit          m_valid;
    bit          m_irq;
    bit          m_pany;
    logic [15:0] acc_q [$];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Advance the model by one clock using the inputs applied before the edge.
    task automatic model_step();
        bit np [NG][NC];
        bit no [NG];
        bit hs;
        bit nany;
        bit found;
        int g;
        int idx;
        if (!aresetn) begin
            for (int i = 0; i < SW; i++) m_prev[i] = 1'b0;
            for (int a = 0; a < NG; a++) begin
                m_ovr[a] = 1'b0;
                for (int b = 0; b < NC; b++) m_pend[a][b] = 1'b0;
            end
            m_rr = 0; m_phase = 0; m_wg = 0; m_wc = 0;
            m_data = 16'h0000; m_valid = 1'b0; m_irq = 1'b0; m_pany = 1'b0;
        end else begin
            hs = (m_phase == 2) && m_valid && evt_ready;
            np = m_pend;
            no = m_ovr;
            if (clr_all) begin
                for (int a = 0; a < NG; a++) begin
                    no[a] = 1'b0;
                    for (int b = 0; b < NC; b++)
                        if (!(m_phase == 2 && a == m_wg && b == m_wc)) np[a][b] = 1'b0;
                end
            end
            if (hs) begin
                np[m_wg][m_wc] = 1'b0;
                no[m_wg] = 1'b0;
            end
            for (int a = 0; a < NG; a++) begin
                for (int b = 0; b < NC; b++) begin
                    idx = a * NC + b;
                    if (sts_in[idx] && !m_prev[idx] && grp_en[a] && (a != 0 || b == 0)) begin
                        if (np[a][b]) no[a] = 1'b1;
                        np[a][b] = 1'b1;
                    end
                end
            end
            nany = 1'b0;
            for (int a = 0; a < NG; a++)
                for (int b = 0; b < NC; b++) nany = nany | np[a][b];
            case (m_phase)
                0: if (m_pany) m_phase = 1;
                1: begin
                    found = 1'b0;
                    if (!clr_all) begin
                        for (int i = 0; i < NG; i++) begin
                            g = (m_rr + i) % NG;
                            for (int b = NC - 1; b >= 0; b--) begin
                                if (!found && m_pend[g][b]) begin
                                    m_wg = g; m_wc = b;
                                end
                            end
                            for (int b = 0; b < NC; b++) if (m_pend[g][b]) found = 1'b1;
                            if (found) break;
                        end
                    end
                    if (found) begin
                        m_data  = 16'(m_wg * 4096 + m_wc * 512 + (m_ovr[m_wg] ? 256 : 0));
                        m_valid = 1'b1;
                        m_phase = 2;
                    end else begin
                        m_phase = 0;
                    end
                end
                default: if (hs) begin
                    m_valid = 1'b0;
                    m_rr    = (m_wg + 1) % NG;
                    m_phase = nany ? 1 : 0;
                end
            endcase
            m_pend = np;
            m_ovr  = no;
            m_pany = nany;
            m_irq  = irq_en && nany;
            for (int i = 0; i < SW; i++) m_prev[i] = sts_in[i];
        end
    endtask

    task automatic cycle_step();
        if (aresetn && evt_valid && evt_ready) acc_q.push_back(evt_data);
        @(posedge aclk);
        model_step();
        #1;
        check_eq("evt_valid", {31'd0, evt_valid}, {31'd0, m_valid});
        check_eq("evt_data", {16'd0, evt_data}, {16'd0, m_data});
        check_eq("irq", {31'd0, irq}, {31'd0, m_irq});
        check_eq("pend_any", {31'd0, pend_any}, {31'd0, m_pany});
    endtask

    task automatic wait_valid(input string tag, input int budget);
        int n = 0;
        while (!evt_valid && n < budget) begin
            cycle_step();
            n++;
        end
        check_eq(tag, {31'd0, evt_valid}, 32'd1);
    endtask

    task automatic wait_acc(input string tag, input int count, input int budget);
        int n = 0;
        while (acc_q.size() < count && n < budget) begin
            cycle_step();
            n++;
        end
        check_eq(tag, acc_q.size(), count);
    endtask

    function automatic logic [15:0] acc_at(input int k);
        return (k < acc_q.size()) ? acc_q[k] : 16'hDEAD;
    endfunction

    task automatic do_reset();
        aresetn = 1'b0;
        cycle_step();
        aresetn = 1'b1;
    endtask

    initial begin
        logic [15:0] exp5;
        aresetn   = 1'b0;
        sts_in    = '0;
        grp_en    = '1;
        clr_all   = 1'b0;
        irq_en    = 1'b1;
        evt_ready = 1'b0;

        // Reset state.
        repeat (3) cycle_step();
        check_eq("rst_valid", {31'd0, evt_valid}, 32'd0);
        check_eq("rst_data", {16'd0, evt_data}, 32'd0);
        check_eq("rst_irq", {31'd0, irq}, 32'd0);
        check_eq("rst_pend_any", {31'd0, pend_any}, 32'd0);

        // 1: latency and encoding of group 4 channel 3.
        aresetn = 1'b1;
        cycle_step();
        sts_in[4*NC+3] = 1'b1;
        cycle_step();
        check_eq("t1_k_valid", {31'd0, evt_valid}, 32'd0);
        cycle_step();
        check_eq("t1_k1_valid", {31'd0, evt_valid}, 32'd0);
        cycle_step();
        check_eq("t1_k2_valid", {31'd0, evt_valid}, 32'd1);
        check_eq("t1_data", {16'd0, evt_data}, 32'h4600);
        check_eq("t1_irq", {31'd0, irq}, 32'd1);
        evt_ready = 1'b1;
        cycle_step();
        evt_ready = 1'b0;
        sts_in = '0;
        repeat (3) cycle_step();
        check_eq("t1_drained", {31'd0, pend_any}, 32'd0);

        // 2: three simultaneous rises served round-robin from pointer 0.
        do_reset();
        acc_q.delete();
        evt_ready = 1'b1;
        sts_in[1*NC+0]  = 1'b1;
        sts_in[5*NC+7]  = 1'b1;
        sts_in[12*NC+2] = 1'b1;
        wait_acc("t2_count", 3, 60);
        check_eq("t2_evt0", {16'd0, acc_at(0)}, 32'h1000);
        check_eq("t2_evt1", {16'd0, acc_at(1)}, 32'h5E00);
        check_eq("t2_evt2", {16'd0, acc_at(2)}, 32'hC400);
        repeat (3) cycle_step();
        check_eq("t2_pend_any", {31'd0, pend_any}, 32'd0);
        check_eq("t2_irq", {31'd0, irq}, 32'd0);

        // 3: rise-fall-rise while the port is busy gives one word with overrun.
        evt_ready = 1'b0;
        sts_in = '0;
        cycle_step();
        acc_q.delete();
        sts_in[6*NC+0] = 1'b1;
        wait_valid("t3_hold_valid", 10);
        sts_in[2*NC+1] = 1'b1; cycle_step();
        sts_in[2*NC+1] = 1'b0; cycle_step();
        sts_in[2*NC+1] = 1'b1; cycle_step();
        evt_ready = 1'b1;
        wait_acc("t3_count", 2, 40);
        check_eq("t3_evt0", {16'd0, acc_at(0)}, 32'h6000);
        check_eq("t3_evt1_ovr", {16'd0, acc_at(1)}, 32'h2300);
        sts_in[2*NC+1] = 1'b0; cycle_step();
        sts_in[2*NC+1] = 1'b1;
        wait_acc("t3_count2", 3, 20);
        check_eq("t3_ovr_cleared", {16'd0, acc_at(2)}, 32'h2200);

        // 4: stalled consumer while new rises arrive.
        evt_ready = 1'b0;
        sts_in = '0;
        cycle_step();
        acc_q.delete();
        sts_in[10*NC+0] = 1'b1;
        wait_valid("t4_valid", 10);
        for (int i = 0; i < 10; i++) begin
            sts_in[$urandom_range(NC, SW-1)] = 1'b1;
            cycle_step();
            check_eq("t4_hold_valid", {31'd0, evt_valid}, 32'd1);
            check_eq("t4_hold_data", {16'd0, evt_data}, 32'hA000);
        end
        evt_ready = 1'b1;
        for (int i = 0; i < 200 && pend_any; i++) cycle_step();
        check_eq("t4_drained", {31'd0, pend_any}, 32'd0);
        check_eq("t4_first", {16'd0, acc_at(0)}, 32'hA000);

        // 5: clr_all while presenting, three more pending.
        evt_ready = 1'b0;
        sts_in = '0;
        repeat (2) cycle_step();
        acc_q.delete();
        sts_in[3*NC+0]  = 1'b1;
        sts_in[7*NC+1]  = 1'b1;
        sts_in[9*NC+5]  = 1'b1;
        sts_in[11*NC+2] = 1'b1;
        wait_valid("t5_valid", 10);
        exp5 = m_data;
        clr_all = 1'b1; cycle_step();
        clr_all = 1'b0; cycle_step();
        evt_ready = 1'b1;
        wait_acc("t5_count", 1, 10);
        check_eq("t5_word", {16'd0, acc_at(0)}, {16'd0, exp5});
        repeat (10) cycle_step();
        check_eq("t5_no_more", acc_q.size(), 1);
        check_eq("t5_pend_any", {31'd0, pend_any}, 32'd0);

        // 6: disabled spi_off group, then reset mid-present and re-report.
        evt_ready = 1'b0;
        sts_in = '0;
        repeat (2) cycle_step();
        grp_en[0] = 1'b0;
        sts_in[0] = 1'b1;
        repeat (6) cycle_step();
        check_eq("t6_disabled_pend", {31'd0, pend_any}, 32'd0);
        check_eq("t6_disabled_valid", {31'd0, evt_valid}, 32'd0);
        grp_en = '1;
        cycle_step();
        sts_in[8*NC+4] = 1'b1;
        wait_valid("t6_valid", 10);
        check_eq("t6_data", {16'd0, evt_data}, 32'h8800);
        aresetn = 1'b0;
        cycle_step();
        check_eq("t6_rst_valid", {31'd0, evt_valid}, 32'd0);
        aresetn = 1'b1;
        acc_q.delete();
        evt_ready = 1'b1;
        wait_acc("t6_count", 2, 30);
        check_eq("t6_evt0", {16'd0, acc_at(0)}, 32'h0000);
        check_eq("t6_evt1", {16'd0, acc_at(1)}, 32'h8800);

        // Randomized traffic against the model.
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 1) == 0) begin
                int b;
                b = $urandom_range(0, SW-1);
                sts_in[b] = ~sts_in[b];
            end
            evt_ready = ($urandom_range(0, 3) != 0);
            clr_all   = ($urandom_range(0, 63) == 0);
            if ($urandom_range(0, 99) == 0) irq_en = ~irq_en;
            if ($urandom_range(0, 199) == 0) grp_en = NG'($urandom);
            aresetn   = ($urandom_range(0, 499) != 0);
            cycle_step();
        end
        aresetn   = 1'b1;
        clr_all   = 1'b0;
        evt_ready = 1'b1;
        repeat (150) cycle_step();
        check_eq("rand_drained", {31'd0, pend_any}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
